// File: rtl/food_spawner_pkg.sv
// food_spawner_pkg
// Shared definitions for the food spawner: coordinate widths, retry counter
// width, default fallback position and the FSM state encoding.
package food_spawner_pkg;

    localparam int X_W            = 10;
    localparam int Y_W            = 9;
    localparam int RETRY_W        = 8;

    localparam int MAX_RETRY_DEF  = 15;
    localparam int FALLBACK_X_DEF = 320;
    localparam int FALLBACK_Y_DEF = 240;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        QUERY  = 2'd2,
        COMMIT = 2'd3
    } state_t;

endpackage

// File: rtl/food_spawner_if.sv
// food_spawner_if
// Occupancy query bus between the food spawner and the snake body logic.
//   qry_valid : query outstanding (spawner -> body logic)
//   qry_x     : candidate x under query
//   qry_y     : candidate y under query
//   occ_valid : answer strobe (body logic -> spawner)
//   occ_hit   : candidate overlaps the snake body, valid with occ_valid
// Modports: master = spawner side, slave = body-logic side.
interface food_spawner_if;
    import food_spawner_pkg::*;

    logic           qry_valid;
    logic [X_W-1:0] qry_x;
    logic [Y_W-1:0] qry_y;
    logic           occ_valid;
    logic           occ_hit;

    modport master (
        output qry_valid, qry_x, qry_y,
        input  occ_valid, occ_hit
    );

    modport slave (
        input  qry_valid, qry_x, qry_y,
        output occ_valid, occ_hit
    );

endinterface

// File: rtl/food_spawner.sv
// food_spawner
// Picks a new food position after the snake eats: samples the free-running
// random coordinates, asks the body logic whether the candidate is occupied,
// and retries on a hit until a free cell is found.
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   randx, randy     : free-running random candidate coordinates
//   eat              : single-cycle pulse, current food has been eaten
//   occ_bus          : occupancy query/answer bus (master side)
//   food_x, food_y   : committed food position
//   food_valid       : food position is live and drawable
//   spawn_done       : one-cycle pulse on each commit
//
// Build option FOOD_RETRY_LIMIT_EN: after MAX_RETRY rejected candidates the
// food is committed at (FALLBACK_X, FALLBACK_Y). Without it retries are
// unbounded and the retry counter saturates.
//
// state  | meaning
// IDLE   | food is live, waiting for eat
// SAMPLE | capture random candidate, raise query
// QUERY  | waiting for occupancy answer
// COMMIT | load food position, pulse spawn_done
module food_spawner
    import food_spawner_pkg::*;
#(
    parameter int MAX_RETRY  = MAX_RETRY_DEF,
    parameter int FALLBACK_X = FALLBACK_X_DEF,
    parameter int FALLBACK_Y = FALLBACK_Y_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [X_W-1:0]        randx,
    input  logic [Y_W-1:0]        randy,
    input  logic                  eat,
    food_spawner_if.master        occ_bus,
    output logic [X_W-1:0]        food_x,
    output logic [Y_W-1:0]        food_y,
    output logic                  food_valid,
    output logic                  spawn_done
);

    if (MAX_RETRY < 1 || MAX_RETRY > 255 ||
        FALLBACK_X >= (1 << X_W) || FALLBACK_Y >= (1 << Y_W)) begin : g_bad_param
        $error("food_spawner: parameter out of range");
    end

    state_t             state;
    logic [RETRY_W-1:0] retry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= SAMPLE;
            retry             <= '0;
            food_x            <= '0;
            food_y            <= '0;
            food_valid        <= 1'b0;
            spawn_done        <= 1'b0;
            occ_bus.qry_valid <= 1'b0;
            occ_bus.qry_x     <= '0;
            occ_bus.qry_y     <= '0;
        end else begin
            spawn_done <= 1'b0;
            case (state)
                IDLE: begin
                    // The spawn_done cycle still belongs to the commit, so an
                    // eat arriving with it is dropped rather than re-arming.
                    if (eat && !spawn_done) begin
                        state      <= SAMPLE;
                        food_valid <= 1'b0;
                    end
                end
                SAMPLE: begin
                    occ_bus.qry_x     <= randx;
                    occ_bus.qry_y     <= randy;
                    occ_bus.qry_valid <= 1'b1;
                    state             <= QUERY;
                end
                QUERY: begin
                    if (occ_bus.occ_valid) begin
                        // Drop the query on every answer so each retry shows
                        // up as a fresh qry_valid rise.
                        occ_bus.qry_valid <= 1'b0;
                        if (!occ_bus.occ_hit) begin
                            state <= COMMIT;
                        end else begin
`ifdef FOOD_RETRY_LIMIT_EN
                            retry <= retry + RETRY_W'(1);
                            if (retry == RETRY_W'(MAX_RETRY - 1)) begin
                                occ_bus.qry_x <= X_W'(FALLBACK_X);
                                occ_bus.qry_y <= Y_W'(FALLBACK_Y);
                                state         <= COMMIT;
                            end else begin
                                state <= SAMPLE;
                            end
`else
                            if (retry != '1) begin
                                retry <= retry + RETRY_W'(1);
                            end
                            state <= SAMPLE;
`endif
                        end
                    end
                end
                COMMIT: begin
                    food_x     <= occ_bus.qry_x;
                    food_y     <= occ_bus.qry_y;
                    food_valid <= 1'b1;
                    spawn_done <= 1'b1;
                    retry      <= '0;
                    state      <= IDLE;
                end
                default: state <= SAMPLE;
            endcase
        end
    end

endmodule

// File: tb/tb_food_spawner.sv
module tb_food_spawner;
    import food_spawner_pkg::*;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           eat   = 1'b0;
    logic [X_W-1:0] randx = '0;
    logic [Y_W-1:0] randy = '0;
    logic [X_W-1:0] food_x;
    logic [Y_W-1:0] food_y;
    logic           food_valid;
    logic           spawn_done;

    food_spawner_if bus();

    food_spawner #(
        .MAX_RETRY  (3),
        .FALLBACK_X (320),
        .FALLBACK_Y (240)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .randx      (randx),
        .randy      (randy),
        .eat        (eat),
        .occ_bus    (bus),
        .food_x     (food_x),
        .food_y     (food_y),
        .food_valid (food_valid),
        .spawn_done (spawn_done)
    );

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          eat_cyc = 0;
    int          spawn_cnt = 0;
    int          exp_spawns = 0;
    int          qry_cnt = 0;
    int          sd_run = 0;
    bit          prev_qv = 1'b0;
    bit          rand_free = 1'b0;
    logic [18:0] exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // free-running random source, overridden while a candidate must be sampled
    initial begin
        forever begin
            @(negedge clk);
            if (rand_free) begin
                randx = X_W'($urandom_range(0, 1023));
                randy = Y_W'($urandom_range(0, 511));
            end
        end
    end

    // scoreboard consumer: every spawn_done pops one expected position
    initial begin
        logic [18:0] e;
        forever begin
            @(negedge clk);
            if (spawn_done) begin
                spawn_cnt++;
                sd_run++;
                chk("spawn_len", sd_run, 1);
                if (exp_q.size() == 0) begin
                    chk("sb_pending", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("food_x", food_x, e[18:9]);
                    chk("food_y", food_y, e[8:0]);
                    chk("food_valid_at_spawn", food_valid, 1);
                end
            end else begin
                sd_run = 0;
            end
            if (bus.qry_valid && !prev_qv) qry_cnt++;
            prev_qv = bus.qry_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Waits for a query, checks the candidate and its stability for lat
    // cycles, then answers; the next candidate is presented with the answer.
    task automatic answer(input int x, input int y, input int lat, input bit hit,
                          input int nx, input int ny);
        int n = 0;
        while (!bus.qry_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("qry_valid", bus.qry_valid, 1);
        chk("qry_x", bus.qry_x, x);
        chk("qry_y", bus.qry_y, y);
        rand_free = 1'b1;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk("qry_x_hold", bus.qry_x, x);
            chk("qry_y_hold", bus.qry_y, y);
            chk("qry_valid_hold", bus.qry_valid, 1);
        end
        bus.occ_valid = 1'b1;
        bus.occ_hit   = hit;
        rand_free     = 1'b0;
        randx         = X_W'(nx);
        randy         = Y_W'(ny);
        if (!hit) exp_q.push_back({X_W'(x), Y_W'(y)});
        @(negedge clk);
        bus.occ_valid = 1'b0;
        bus.occ_hit   = 1'($urandom_range(0, 1));
        chk("qry_drop", bus.qry_valid, 0);
    endtask

    task automatic eat_pulse(input int x, input int y);
        rand_free = 1'b0;
        randx     = X_W'(x);
        randy     = Y_W'(y);
        eat       = 1'b1;
        eat_cyc   = cyc;
        @(negedge clk);
        eat       = 1'b0;
        chk("fv_after_eat", food_valid, 0);
    endtask

    task automatic wait_food();
        int n = 0;
        while (!food_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("food_valid", food_valid, 1);
    endtask

    task automatic wait_qry();
        int n = 0;
        while (!bus.qry_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("qry_seen", bus.qry_valid, 1);
    endtask

    initial begin
        int n;
        int qbase;
        bus.occ_valid = 1'b0;
        bus.occ_hit   = 1'b0;
        randx = 10'd120;
        randy = 9'd150;
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_food_valid", food_valid, 0);
        chk("rst_spawn_done", spawn_done, 0);
        chk("rst_qry_valid", bus.qry_valid, 0);
        chk("rst_qry_x", bus.qry_x, 0);
        chk("rst_qry_y", bus.qry_y, 0);
        chk("rst_food_x", food_x, 0);
        chk("rst_food_y", food_y, 0);
        chk("rst_retry", dut.retry, 0);

        // first food spawns without eat
        rst_n = 1'b1;
        exp_spawns++;
        answer(120, 150, 2, 1'b0, 0, 0);
        wait_food();
        @(negedge clk);
        chk("spawn_done_low", spawn_done, 0);
        chk("food_valid_hold", food_valid, 1);

        // two hits then a miss
        exp_spawns++;
        eat_pulse(11, 22);
        answer(11, 22, 1, 1'b1, 33, 44);
        chk("retry_1", dut.retry, 1);
        answer(33, 44, 3, 1'b1, 300, 200);
        chk("retry_2", dut.retry, 2);
        answer(300, 200, 0, 1'b0, 0, 0);
        wait_food();
        @(negedge clk);
        chk("retry_clear", dut.retry, 0);

        // minimum eat-to-food latency
        exp_spawns++;
        eat_pulse(5, 6);
        answer(5, 6, 0, 1'b0, 0, 0);
        wait_food();
        chk("eat_to_food", cyc - eat_cyc, 4);
        @(negedge clk);

        // eat during query and on the spawn_done cycle are ignored
        exp_spawns++;
        eat_pulse(400, 100);
        wait_qry();
        rand_free = 1'b1;
        eat = 1'b1;
        @(negedge clk);
        eat = 1'b0;
        answer(400, 100, 1, 1'b0, 0, 0);
        n = 0;
        while (!spawn_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("spawn_seen", spawn_done, 1);
        eat = 1'b1;
        @(negedge clk);
        eat = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_rearm_qv", bus.qry_valid, 0);
            chk("no_rearm_fv", food_valid, 1);
        end
        chk("spawn_cnt_mid", spawn_cnt, exp_spawns);

        // reset mid-query, stale answer right after release
        eat_pulse(500, 60);
        wait_qry();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_qry_valid", bus.qry_valid, 0);
        chk("mrst_food_valid", food_valid, 0);
        chk("mrst_food_x", food_x, 0);
        chk("mrst_retry", dut.retry, 0);
        rand_free = 1'b0;
        randx = 10'd77;
        randy = 9'd88;
        @(negedge clk);
        rst_n = 1'b1;
        bus.occ_valid = 1'b1;
        bus.occ_hit   = 1'b0;
        @(negedge clk);
        bus.occ_valid = 1'b0;
        chk("mrst_new_qry", bus.qry_valid, 1);
        chk("mrst_qry_x", bus.qry_x, 77);
        chk("mrst_qry_y", bus.qry_y, 88);
        @(negedge clk);
        chk("mrst_no_spawn", spawn_done, 0);
        chk("mrst_qry_held", bus.qry_valid, 1);
        exp_spawns++;
        answer(77, 88, 1, 1'b0, 0, 0);
        wait_food();
        @(negedge clk);

`ifdef FOOD_RETRY_LIMIT_EN
        // retry limit: three hits commit the fallback position
        exp_spawns++;
        eat_pulse(1, 2);
        qbase = qry_cnt;
        answer(1, 2, 0, 1'b1, 3, 4);
        answer(3, 4, 1, 1'b1, 5, 6);
        exp_q.push_back({10'd320, 9'd240});
        answer(5, 6, 0, 1'b1, 7, 8);
        wait_food();
        chk("fb_queries", qry_cnt - qbase, 3);
        @(negedge clk);
        chk("fb_retry_clear", dut.retry, 0);
`else
        // unbounded retries: counter saturates at 255
        exp_spawns++;
        eat_pulse(0, 0);
        for (int i = 0; i < 256; i++) begin
            answer(i, i, 0, 1'b1, i + 1, i + 1);
        end
        chk("retry_sat", dut.retry, 255);
        answer(256, 256, 0, 1'b0, 0, 0);
        wait_food();
        @(negedge clk);
        chk("sat_retry_clear", dut.retry, 0);
`endif

        repeat (2) @(negedge clk);
        chk("spawn_cnt_end", spawn_cnt, exp_spawns);
        chk("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/food_spawner.md
FOOD_SPAWNER -- requirements
Module: food_spawner

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 15, maximum rejected candidates before fallback (1..255).
REQ-002 SHALL have parameter FALLBACK_X, default 320, x committed when the retry limit is hit.
REQ-003 SHALL have parameter FALLBACK_Y, default 240, y committed when the retry limit is hit.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port randx  input  10  free-running random x candidate, sampled, never held.
REQ-007 SHALL have port randy  input  9  free-running random y candidate.
REQ-008 SHALL have port eat  input  1  single-cycle pulse; snake has eaten current food.
REQ-009 SHALL have port qry_valid  output  1  occupancy query outstanding.
REQ-010 SHALL have ports qry_x / qry_y  output  10 / 9  candidate under query.
REQ-011 SHALL have port occ_valid  input  1  occupancy answer strobe from snake body logic.
REQ-012 SHALL have port occ_hit  input  1  candidate overlaps snake body; meaningful only with occ_valid.
REQ-013 SHALL have ports food_x / food_y  output  10 / 9  committed food position.
REQ-014 SHALL have port food_valid  output  1  food_x/food_y are live and drawable.
REQ-015 SHALL have port spawn_done  output  1  one-cycle pulse on each commit.

Function
REQ-016 SHALL implement FSM states IDLE, SAMPLE, QUERY, COMMIT.
REQ-017 IDLE: food_valid=1; on eat -> SAMPLE, food_valid=0 next cycle.
REQ-018 SAMPLE: register randx/randy into qry_x/qry_y, assert qry_valid -> QUERY (1 cycle).
REQ-019 QUERY: hold qry_valid and qry_x/qry_y stable until occ_valid=1; answer latency unbounded.
REQ-020 QUERY, occ_valid=1, occ_hit=0 -> COMMIT; qry_valid=0 next cycle.
REQ-021 QUERY, occ_valid=1, occ_hit=1 -> increment 8-bit retry counter, -> SAMPLE.
REQ-022 occ_valid outside QUERY SHALL be ignored.
REQ-023 COMMIT: load food_x/food_y from candidate, pulse spawn_done, food_valid=1, clear retry counter, -> IDLE (1 cycle).
REQ-024 eat while not IDLE SHALL be ignored (no queueing; food already invalid).
REQ-025 eat and spawn_done in the same cycle: eat ignored (FSM not yet IDLE).
REQ-026 Minimum eat-to-food_valid latency: 4 cycles with zero-latency occupancy answer.
REQ-027 Coordinates pass through unmodified; no arithmetic on x/y.

Reset
REQ-028 Async assertion: state=SAMPLE, food_valid=0, spawn_done=0, qry_valid=0, qry_x/qry_y=0, food_x/food_y=0, retry=0.
REQ-029 First food SHALL be spawned automatically after reset deassertion, no eat required.
REQ-030 Reset mid-query SHALL abandon the query; late occ_valid after reset is ignored per REQ-022 until re-queried.

Configuration
REQ-031 Macro FOOD_RETRY_LIMIT_EN defined: when retry reaches MAX_RETRY on a hit, next state COMMIT with FALLBACK_X/FALLBACK_Y (no further query).
REQ-032 Macro FOOD_RETRY_LIMIT_EN undefined: retries unbounded; retry counter saturates at 255; parameters MAX_RETRY/FALLBACK_* unused.

Structure
REQ-033 Shared package SHALL hold FSM state enum, X_W=10, Y_W=9, default fallback constants.
REQ-034 No sub-module; single flat FSM + datapath register.

Verification
REQ-035 Reset release, randx=120/randy=150, occ answers miss after 2 cycles -> food=(120,150), food_valid=1, spawn_done one pulse.
REQ-036 eat with occ_hit=1 twice then miss at randx=300/randy=200 -> retry reaches 2, food=(300,200), qry_x/y stable while waiting.
REQ-037 FOOD_RETRY_LIMIT_EN, MAX_RETRY=3, occ_hit always 1 -> food=(320,240) after 3rd hit, exactly 3 queries.
REQ-038 eat pulsed during QUERY and on spawn_done cycle -> ignored; exactly one spawn_done per accepted eat.
REQ-039 rst_n low while qry_valid=1, occ_valid arrives 1 cycle after release -> ignored, new query issued with freshly sampled candidate.
